// File: rtl/multi_psg_ctrl.sv
// multi_psg_ctrl: host bus front-end that queues register writes to several PSG/FM chips and mixes their FM outputs
module multi_psg_ctrl #(
  parameter int NCHIPS      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WR_GAP      = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CE,
  input  logic                   BDIR,
  input  logic                   BC,
  input  logic [7:0]             DI,
  output logic [7:0]             DO,
  output logic [NCHIPS-1:0]      CHIP_CS_N,
  output logic                   CHIP_ADDR,
  output logic                   CHIP_WR_N,
  output logic [7:0]             CHIP_DI,
  input  logic [8*NCHIPS-1:0]    CHIP_DO,
  input  logic [16*NCHIPS-1:0]   CHIP_FM,
  output logic [15*NCHIPS-1:0]   FM_OUT,
  output logic [15:0]            FM_MIX,
  output logic                   OVF
);
  localparam int CW = NCHIPS > 1 ? $clog2(NCHIPS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = WR_GAP > 1 ? $clog2(WR_GAP) : 1;
  typedef struct packed {
    logic [CW-1:0] chip;
    logic          a0;
    logic [7:0]    data;
  } entry_t;
  logic [9:0] sync_q [SYNC_STAGES];
  logic bdir_q, bdir_s, bc_s, access, push, accept, issue, full;
  logic [7:0] di_s;
  logic [CW-1:0] sel_q, sel_d, chip_q;
  logic stat_q, stat_d, fm_ena_q, fm_ena_d, acc_q, acc_d;
  entry_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic wr_n_q, a0_q, ovf_q;
  logic [7:0] di_q;
  logic [15*NCHIPS-1:0] fm_q, fm_d;
  logic [15:0] mix_q, mix_d;
  logic [18:0] sum;
  assign {bdir_s, bc_s, di_s} = sync_q[SYNC_STAGES-1];
  assign access = bdir_s & ~bdir_q;
  assign full   = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign issue  = cnt_q != '0 && gap_q == '0 && CE;
  assign accept = push && (!full || issue);
  always_comb begin
    sel_d    = sel_q;
    stat_d   = stat_q;
    fm_ena_d = fm_ena_q;
    acc_d    = acc_q;
    push     = 1'b0;
    if (access && bc_s && di_s[7:3] == 5'b11111) begin
      sel_d    = NCHIPS > 1 ? CW'(di_s[0]) : '0;
      stat_d   = di_s[1];
      fm_ena_d = ~di_s[2];
      acc_d    = 1'b0;
    end else if (access && bc_s && NCHIPS > 2 && di_s[7:3] == 5'b11100) begin
      sel_d = 32'(di_s[2:0]) < NCHIPS ? CW'(di_s[2:0]) : sel_q;
      acc_d = 1'b0;
    end else if (access && bc_s) begin
      acc_d = di_s[7:4] == 4'h0 || fm_ena_q;
      push  = acc_d;
    end else if (access) begin
      push = acc_q;
    end
  end
  always_comb begin
    fm_d = '0;
    sum  = '0;
    for (int i = 0; i < NCHIPS; i++) begin
      fm_d[15*i +: 15] = fm_ena_q ? (CHIP_FM[16*i+15] ? ~CHIP_FM[16*i +: 15] : CHIP_FM[16*i +: 15]) : 15'h0;
      sum = sum + 19'(fm_q[15*i +: 15]);
    end
    mix_d = |sum[18:16] ? 16'hFFFF : sum[15:0];
  end
  // queue storage needs no reset: occupancy is tracked by cnt_q
  always_ff @(posedge CLK) begin
    if (accept) mem_q[wr_q] <= '{chip: sel_q, a0: ~bc_s, data: di_s};
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bdir_q   <= 1'b0;
      sel_q    <= NCHIPS > 1 ? CW'(1) : '0;
      stat_q   <= 1'b1;
      fm_ena_q <= 1'b0;
      acc_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      ovf_q    <= 1'b0;
      wr_n_q   <= 1'b1;
      chip_q   <= '0;
      a0_q     <= 1'b0;
      di_q     <= '0;
      fm_q     <= '0;
      mix_q    <= '0;
    end else begin
      sync_q[0] <= {BDIR, BC, DI};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bdir_q   <= bdir_s;
      sel_q    <= sel_d;
      stat_q   <= stat_d;
      fm_ena_q <= fm_ena_d;
      acc_q    <= acc_d;
      wr_q     <= accept ? wr_q + AW'(1) : wr_q;
      rd_q     <= issue ? rd_q + AW'(1) : rd_q;
      cnt_q    <= cnt_q + (AW+1)'(accept) - (AW+1)'(issue);
      ovf_q    <= ovf_q | (push & ~accept);
      gap_q    <= issue ? GW'(WR_GAP - 1) : gap_q != '0 ? gap_q - GW'(1) : gap_q;
      wr_n_q   <= ~issue;
      chip_q   <= issue ? mem_q[rd_q].chip : chip_q;
      a0_q     <= issue ? mem_q[rd_q].a0 : a0_q;
      di_q     <= issue ? mem_q[rd_q].data : di_q;
      fm_q     <= fm_d;
      mix_q    <= mix_d;
    end
  end
  assign CHIP_WR_N = wr_n_q;
  assign CHIP_CS_N = ~(NCHIPS'(1) << (wr_n_q ? sel_q : chip_q));
  assign CHIP_ADDR = wr_n_q ? stat_q : a0_q;
  assign CHIP_DI   = di_q;
  assign DO        = CHIP_DO[{sel_q, 3'b000} +: 8];
  assign FM_OUT    = fm_q;
  assign FM_MIX    = mix_q;
  assign OVF       = ovf_q;
endmodule

// File: tb/tb_multi_psg_ctrl.sv
// tb_multi_psg_ctrl: directed vector table plus hand-written sequences for queueing, overflow, FM mix and reset
module tb_multi_psg_ctrl;
  localparam int SS = 2;
  localparam int WG = 3;
  logic CLK = 1'b0, RESET, CE, BDIR, BC;
  logic [7:0] DI, DO, DO4, CHIP_DI, CHIP_DI4;
  logic [1:0] CHIP_CS_N;
  logic [3:0] CHIP_CS_N4;
  logic CHIP_ADDR, CHIP_WR_N, OVF, CHIP_ADDR4, CHIP_WR_N4, OVF4;
  logic [15:0] CHIP_DO = {8'hB2, 8'hA1};
  logic [31:0] CHIP_DO4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [31:0] CHIP_FM;
  logic [63:0] CHIP_FM4;
  logic [29:0] FM_OUT;
  logic [59:0] FM_OUT4;
  logic [15:0] FM_MIX, FM_MIX4;
  int checks = 0, errors = 0, cyc = 0, cnt4 = 0, s0, n4, t0;
  logic [3:0] cs4_l;
  logic a04_l;
  logic [7:0] d4_l;
  typedef struct {logic [1:0] cs; logic a0; logic [7:0] d; int cyc;} stb_t;
  stb_t slog[$];
  typedef struct {
    logic bc; logic [7:0] di; int n; logic [1:0] cs; logic a0; logic [7:0] d;
    logic [7:0] do_e; logic addr; logic [1:0] idle_cs; logic [7:0] last;
  } vec_t;
  vec_t tbl[12];
  logic [7:0] ovd[4];

  multi_psg_ctrl #(.NCHIPS(2), .FIFO_DEPTH(4), .SYNC_STAGES(SS), .WR_GAP(WG)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI), .DO(DO),
    .CHIP_CS_N(CHIP_CS_N), .CHIP_ADDR(CHIP_ADDR), .CHIP_WR_N(CHIP_WR_N), .CHIP_DI(CHIP_DI),
    .CHIP_DO(CHIP_DO), .CHIP_FM(CHIP_FM), .FM_OUT(FM_OUT), .FM_MIX(FM_MIX), .OVF(OVF));
  multi_psg_ctrl #(.NCHIPS(4), .FIFO_DEPTH(4), .SYNC_STAGES(SS), .WR_GAP(WG)) dut4 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI), .DO(DO4),
    .CHIP_CS_N(CHIP_CS_N4), .CHIP_ADDR(CHIP_ADDR4), .CHIP_WR_N(CHIP_WR_N4), .CHIP_DI(CHIP_DI4),
    .CHIP_DO(CHIP_DO4), .CHIP_FM(CHIP_FM4), .FM_OUT(FM_OUT4), .FM_MIX(FM_MIX4), .OVF(OVF4));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // strobes last a whole cycle, so the falling edge sees each one exactly once
  always @(negedge CLK) begin
    if (CHIP_WR_N === 1'b0) slog.push_back('{CHIP_CS_N, CHIP_ADDR, CHIP_DI, cyc});
    if (CHIP_WR_N4 === 1'b0) begin
      cnt4++;
      cs4_l = CHIP_CS_N4;
      a04_l = CHIP_ADDR4;
      d4_l  = CHIP_DI4;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic bc, input logic [7:0] d);
    tick(1);
    BC = bc;
    DI = d;
    BDIR = 1'b1;
    tick(SS + 1);
    BDIR = 1'b0;
    tick(SS + 1);
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; BDIR = 1'b0; BC = 1'b0; DI = '0; CHIP_FM = '0; CHIP_FM4 = '0;
    tbl[0]  = '{1'b1, 8'h07, 1, 2'b01, 1'b0, 8'h07, 8'hB2, 1'b1, 2'b01, 8'h07};
    tbl[1]  = '{1'b0, 8'h38, 1, 2'b01, 1'b1, 8'h38, 8'hB2, 1'b1, 2'b01, 8'h38};
    tbl[2]  = '{1'b1, 8'h28, 0, 2'b00, 1'b0, 8'h00, 8'hB2, 1'b1, 2'b01, 8'h38};
    tbl[3]  = '{1'b0, 8'hF0, 0, 2'b00, 1'b0, 8'h00, 8'hB2, 1'b1, 2'b01, 8'h38};
    tbl[4]  = '{1'b1, 8'hFB, 0, 2'b00, 1'b0, 8'h00, 8'hB2, 1'b1, 2'b01, 8'h38};
    tbl[5]  = '{1'b1, 8'h28, 1, 2'b01, 1'b0, 8'h28, 8'hB2, 1'b1, 2'b01, 8'h28};
    tbl[6]  = '{1'b0, 8'hF0, 1, 2'b01, 1'b1, 8'hF0, 8'hB2, 1'b1, 2'b01, 8'hF0};
    tbl[7]  = '{1'b1, 8'hFE, 0, 2'b00, 1'b0, 8'h00, 8'hA1, 1'b1, 2'b10, 8'hF0};
    tbl[8]  = '{1'b1, 8'h07, 1, 2'b10, 1'b0, 8'h07, 8'hA1, 1'b1, 2'b10, 8'h07};
    tbl[9]  = '{1'b0, 8'h3F, 1, 2'b10, 1'b1, 8'h3F, 8'hA1, 1'b1, 2'b10, 8'h3F};
    tbl[10] = '{1'b1, 8'hFC, 0, 2'b00, 1'b0, 8'h00, 8'hA1, 1'b0, 2'b10, 8'h3F};
    tbl[11] = '{1'b1, 8'hFF, 0, 2'b00, 1'b0, 8'h00, 8'hB2, 1'b1, 2'b01, 8'h3F};
    ovd = '{8'h07, 8'h11, 8'h22, 8'h33};
    tick(2);
    chk("rst_wr_n", CHIP_WR_N, 1'b1);
    chk("rst_cs", CHIP_CS_N, 2'b01);
    chk("rst_addr", CHIP_ADDR, 1'b1);
    chk("rst_ovf", OVF, 1'b0);
    chk("rst_mix", FM_MIX, 16'h0);
    chk("rst_do", DO, 8'hB2);
    chk("rst_cs4", CHIP_CS_N4, 4'b1101);
    RESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s0 = slog.size();
      bus(tbl[i].bc, tbl[i].di);
      tick(10);
      chk($sformatf("row%0d_nstb", i), slog.size() - s0, tbl[i].n);
      if (tbl[i].n == 1 && slog.size() > s0) begin
        chk($sformatf("row%0d_cs", i), slog[s0].cs, tbl[i].cs);
        chk($sformatf("row%0d_a0", i), slog[s0].a0, tbl[i].a0);
        chk($sformatf("row%0d_d", i), slog[s0].d, tbl[i].d);
      end
      chk($sformatf("row%0d_do", i), DO, tbl[i].do_e);
      chk($sformatf("row%0d_addr", i), CHIP_ADDR, tbl[i].addr);
      chk($sformatf("row%0d_idle_cs", i), CHIP_CS_N, tbl[i].idle_cs);
      chk($sformatf("row%0d_last", i), CHIP_DI, tbl[i].last);
    end
    // queued entries keep their chip even after a later reselect
    CE = 1'b0;
    s0 = slog.size();
    bus(1'b1, 8'hFE); bus(1'b1, 8'h07); bus(1'b0, 8'h3F); bus(1'b1, 8'hFF);
    chk("hold_nstb", slog.size() - s0, 0);
    chk("hold_idle_cs", CHIP_CS_N, 2'b01);
    CE = 1'b1;
    tick(12);
    chk("retgt_nstb", slog.size() - s0, 2);
    if (slog.size() >= s0 + 2) begin
      chk("retgt_cs0", slog[s0].cs, 2'b10);
      chk("retgt_d0", {slog[s0].a0, slog[s0].d}, {1'b0, 8'h07});
      chk("retgt_cs1", slog[s0+1].cs, 2'b10);
      chk("retgt_d1", {slog[s0+1].a0, slog[s0+1].d}, {1'b1, 8'h3F});
      chk("gap_min", (slog[s0+1].cyc - slog[s0].cyc) >= WG, 1'b1);
    end
    CE = 1'b0;
    s0 = slog.size();
    chk("ovf_pre", OVF, 1'b0);
    bus(1'b1, 8'h07); bus(1'b0, 8'h11); bus(1'b0, 8'h22); bus(1'b0, 8'h33); bus(1'b0, 8'h44);
    chk("ovf_set", OVF, 1'b1);
    CE = 1'b1;
    tick(20);
    chk("ovf_nstb", slog.size() - s0, 4);
    for (int i = 0; i < 4; i++)
      if (slog.size() > s0 + i)
        chk($sformatf("ovf_e%0d", i), {slog[s0+i].cs, slog[s0+i].a0, slog[s0+i].d}, {2'b01, i != 0, ovd[i]});
    chk("ovf_sticky", OVF, 1'b1);
    s0 = slog.size();
    tick(1);
    BC = 1'b1; DI = 8'h05; BDIR = 1'b1; t0 = cyc;
    tick(8);
    BDIR = 1'b0;
    tick(8);
    chk("lat_nstb", slog.size() - s0, 1);
    if (slog.size() > s0) chk("lat_min", (slog[s0].cyc - t0) >= SS + 2, 1'b1);
    bus(1'b1, 8'hFB);
    CHIP_FM = {16'h7FFF, 16'h8000};
    CHIP_FM4 = {4{16'h7FFF}};
    tick(3);
    chk("fm_out", FM_OUT, {15'h7FFF, 15'h7FFF});
    chk("fm_mix", FM_MIX, 16'hFFFE);
    chk("fm_mix4_sat", FM_MIX4, 16'hFFFF);
    CHIP_FM = {16'h0003, 16'hFFFE};
    tick(3);
    chk("fm_out2", FM_OUT, {15'h0003, 15'h0001});
    chk("fm_mix2", FM_MIX, 16'h0004);
    bus(1'b1, 8'hFF);
    tick(3);
    chk("fm_off_out", FM_OUT, 30'h0);
    chk("fm_off_mix", FM_MIX, 16'h0);
    CE = 1'b0;
    s0 = slog.size();
    bus(1'b1, 8'h07); bus(1'b0, 8'h55);
    RESET = 1'b1;
    #1;
    chk("mid_rst_ovf", OVF, 1'b0);
    chk("mid_rst_wr_n", CHIP_WR_N, 1'b1);
    chk("mid_rst_cs", CHIP_CS_N, 2'b01);
    tick(1);
    RESET = 1'b0;
    CE = 1'b1;
    tick(15);
    chk("mid_rst_flush", slog.size() - s0, 0);
    bus(1'b1, 8'hE3);
    tick(4);
    chk("ext_cs4", CHIP_CS_N4, 4'b0111);
    chk("ext_do4", DO4, 8'hD4);
    n4 = cnt4;
    bus(1'b1, 8'h01);
    tick(10);
    chk("ext_nstb", cnt4 - n4, 1);
    chk("ext_stb", {cs4_l, a04_l, d4_l}, {4'b0111, 1'b0, 8'h01});
    bus(1'b1, 8'hE5);
    tick(4);
    chk("ext_ign_cs4", CHIP_CS_N4, 4'b0111);
    chk("ext_ign_do4", DO4, 8'hD4);
    n4 = cnt4;
    bus(1'b0, 8'h99);
    tick(10);
    chk("ext_acc_clr", cnt4 - n4, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_psg_ctrl.md
MULTI_PSG_CTRL -- requirements
Module: multi_psg_ctrl

Interface
REQ-001 SHALL have parameter NCHIPS, default 2, number of attached PSG/FM chips (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, write-queue entries (power of 2, 2..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, bus-input synchroniser depth (>=2).
REQ-004 SHALL have parameter WR_GAP, default 2, minimum CLK cycles between chip write strobes (>=1).
REQ-005 SHALL have port CLK  in  1  global clock, all logic on rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous active-high reset.
REQ-007 SHALL have port CE  in  1  chip clock enable; write strobes are issued only when CE=1.
REQ-008 SHALL have ports BDIR  in  1  bus direction (1=write), and BC  in  1  bus control (1=address/command).
REQ-009 SHALL have ports DI  in  8  host data, and DO  out  8  host read data.
REQ-010 SHALL have ports CHIP_CS_N  out  NCHIPS  per-chip select, active low, and CHIP_ADDR  out  1  chip A0.
REQ-011 SHALL have ports CHIP_WR_N  out  1  write strobe, active low, and CHIP_DI  out  8  chip write data.
REQ-012 SHALL have ports CHIP_DO  in  8*NCHIPS  per-chip read data, and CHIP_FM  in  16*NCHIPS  per-chip signed FM.
REQ-013 SHALL have ports FM_OUT  out  15*NCHIPS  per-chip FM magnitude, FM_MIX  out  16  saturated sum, and OVF  out  1  sticky overflow.

Function
REQ-014 SHALL pass BDIR, BC, DI through SYNC_STAGES flops; all decoding uses synchronised copies; an access is a rising edge of synchronised BDIR.
REQ-015 SHALL treat BC=1 with DI[7:3]=11111 as select command: sel<=DI[0], stat_sel<=DI[1], fm_ena<=~DI[2], acc<=0; no queue push.
REQ-016 SHALL, when NCHIPS>2, treat BC=1 with DI[7:3]=11100 as extended select: sel<=DI[2:0] if DI[2:0]<NCHIPS, else ignored; acc<=0; no push; when NCHIPS<=2 the code is an ordinary address.
REQ-017 SHALL treat any other BC=1 access as address write: acc<=(DI[7:4]==0)|fm_ena; if acc-new is 1, push {sel, A0=0, DI}.
REQ-018 SHALL treat BC=0 access as data write: push {sel, A0=1, DI} only if acc=1; acc unchanged.
REQ-019 SHALL store the chip index in each queue entry; later select commands do not retarget queued entries.
REQ-020 SHALL issue a queued write when queue non-empty, gap counter=0 and CE=1: for exactly one cycle CHIP_WR_N=0, CHIP_CS_N low only for entry's chip, CHIP_ADDR=entry A0, CHIP_DI=entry data; pop; gap counter<=WR_GAP-1.
REQ-021 SHALL decrement the gap counter each cycle while non-zero, independent of CE.
REQ-022 SHALL, when no write issued, drive CHIP_WR_N=1, CHIP_CS_N low for selected chip only, CHIP_ADDR=stat_sel, CHIP_DI=last written data.
REQ-023 SHALL drive DO combinationally from CHIP_DO slice of sel.
REQ-024 SHALL, on push with queue full, drop the entry and set OVF=1; OVF clears only on RESET.
REQ-025 SHALL, on simultaneous push and pop, perform both; occupancy unchanged; full queue with simultaneous pop accepts the push.
REQ-026 SHALL register FM_OUT per chip each cycle: fm_ena ? (FM[15] ? ~FM[14:0] : FM[14:0]) : 0.
REQ-027 SHALL register FM_MIX = sum of all FM_OUT slices, saturated to 16'hFFFF, one cycle after FM_OUT.
REQ-028 SHALL issue the first write strobe no earlier than SYNC_STAGES+2 cycles after BDIR rises at the pin.

Reset
REQ-029 SHALL on RESET asynchronously set sel=1 (0 if NCHIPS=1), stat_sel=1, fm_ena=0, acc=0, queue empty, gap=0, OVF=0, CHIP_WR_N=1, FM_OUT=0, FM_MIX=0, synchronisers and edge detector to 0.
REQ-030 SHALL, on RESET mid-operation, discard queued writes and release any active strobe immediately.

Verification
REQ-031 Reset, CE=1, write addr 0x07 then data 0x38 -> two strobes on chip1: A0=0/0x07, then A0=1/0x38, >=WR_GAP cycles apart.
REQ-032 Select 0xFE, write addr 0x07, data 0x3F, then select 0xFF before drain -> both strobes still target chip0 (CHIP_CS_N=2'b10).
REQ-033 fm_ena=0, write addr 0x28 then data 0xF0 -> no strobes; after select 0xFB (fm_ena=1) same sequence -> two strobes.
REQ-034 CE held 0, FIFO_DEPTH+1 pushes -> OVF=1, first FIFO_DEPTH entries drained in order once CE=1, last dropped.
REQ-035 NCHIPS=4, extended select 0xE3, write addr 0x01 -> strobe with CHIP_CS_N=4'b0111; 0xE5 ignored (sel stays 3).
REQ-036 fm_ena=1, CHIP_FM={16'h7FFF,16'h8000} -> FM_OUT={15'h7FFF,15'h7FFF}, FM_MIX=16'hFFFE; fm_ena=0 -> all 0.
